// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution address-generation blocks.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Counter width for a modulus; a modulus of 1 or 2 still needs one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with enable; tc flags the terminal count regardless of en.
module mod_counter
  import cnn_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [cnt_w(MOD)-1:0] count,
  output logic                  tc
);

  localparam int W = cnt_w(MOD);

  assign tc = (count == W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every valid-mode convolution window and streams image/kernel read
// addresses downstream. Handshake: a beat transfers on a rising edge where valid && ready; while valid && !ready all outputs hold.
module conv_window_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int IMG_AW = 6,
  parameter int KER_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [IMG_AW-1:0] img_addr,
  output logic [KER_AW-1:0] ker_addr,
  output logic              valid,
  input  logic              ready,
  output logic              win_last,
  output logic              frame_last,
  output logic              done,
  output state_t            state
);

  localparam int OW  = (IMG_W - K) / STRIDE + 1;
  localparam int OH  = (IMG_H - K) / STRIDE + 1;
  localparam int KW  = cnt_w(K);
  localparam int OWW = cnt_w(OW);
  localparam int OHW = cnt_w(OH);

  state_t state_nx;

  logic [KW-1:0]  kc, kr, kc_nx, kr_nx;
  logic [OWW-1:0] oc, oc_nx;
  logic [OHW-1:0] orow, orow_nx;
  logic           kc_tc, kr_tc, oc_tc, orow_tc;
  logic           advance, en_kr, en_oc, en_or;
  logic           run_nx, win_last_d, frame_last_d;
  logic [IMG_AW-1:0] img_d;
  logic [KER_AW-1:0] ker_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        advance = ready;
        if (ready && kc_tc && kr_tc && oc_tc && orow_tc) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign en_kr = advance & kc_tc;
  assign en_oc = en_kr & kr_tc;
  assign en_or = en_oc & oc_tc;

  mod_counter #(.MOD(K))  u_kc (.clk(clk), .rst(rst), .en(advance), .count(kc),   .tc(kc_tc));
  mod_counter #(.MOD(K))  u_kr (.clk(clk), .rst(rst), .en(en_kr),   .count(kr),   .tc(kr_tc));
  mod_counter #(.MOD(OW)) u_oc (.clk(clk), .rst(rst), .en(en_oc),   .count(oc),   .tc(oc_tc));
  mod_counter #(.MOD(OH)) u_or (.clk(clk), .rst(rst), .en(en_or),   .count(orow), .tc(orow_tc));

  // Output registers load the position the counters move to on this edge,
  // so the presented beat always matches the counter state.
  always_comb begin
    kc_nx   = advance ? (kc_tc ? '0 : kc + 1'b1) : kc;
    kr_nx   = en_kr   ? (kr_tc ? '0 : kr + 1'b1) : kr;
    oc_nx   = en_oc   ? (oc_tc ? '0 : oc + 1'b1) : oc;
    orow_nx = en_or   ? (orow_tc ? '0 : orow + 1'b1) : orow;
    run_nx  = (state_nx == ST_RUN);
    img_d   = IMG_AW'((32'(orow_nx) * STRIDE + 32'(kr_nx)) * IMG_W
                      + 32'(oc_nx) * STRIDE + 32'(kc_nx));
    ker_d   = KER_AW'(32'(kr_nx) * K + 32'(kc_nx));
    win_last_d   = run_nx && (kc_nx == KW'(K - 1)) && (kr_nx == KW'(K - 1));
    frame_last_d = win_last_d && (oc_nx == OWW'(OW - 1)) && (orow_nx == OHW'(OH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_addr   <= '0;
      ker_addr   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_last   <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      img_addr   <= run_nx ? img_d : '0;
      ker_addr   <= run_nx ? ker_d : '0;
      valid      <= run_nx;
      busy       <= run_nx;
      done       <= (state_nx == ST_DONE);
      win_last   <= win_last_d;
      frame_last <= frame_last_d;
    end
  end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: three geometries, directed frames with random ready.
module tb_conv_window_addr_gen;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst, start, ready;
  always #5 clk = ~clk;

  logic [5:0] img_a [3];
  logic [3:0] ker_a [3];
  logic       valid_a [3], busy_a [3], done_a [3], wl_a [3], fl_a [3];
  state_t     st_a [3];

  int cfg;
  int cw [3] = '{4, 5, 2};
  int ch [3] = '{4, 5, 2};
  int ck [3] = '{3, 3, 1};
  int cs [3] = '{1, 2, 1};

  conv_window_addr_gen #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .IMG_AW(6), .KER_AW(4)) u_a (
    .clk(clk), .rst(rst), .start(start && cfg == 0), .busy(busy_a[0]), .img_addr(img_a[0]),
    .ker_addr(ker_a[0]), .valid(valid_a[0]), .ready(ready), .win_last(wl_a[0]),
    .frame_last(fl_a[0]), .done(done_a[0]), .state(st_a[0]));
  conv_window_addr_gen #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .IMG_AW(6), .KER_AW(4)) u_b (
    .clk(clk), .rst(rst), .start(start && cfg == 1), .busy(busy_a[1]), .img_addr(img_a[1]),
    .ker_addr(ker_a[1]), .valid(valid_a[1]), .ready(ready), .win_last(wl_a[1]),
    .frame_last(fl_a[1]), .done(done_a[1]), .state(st_a[1]));
  conv_window_addr_gen #(.IMG_W(2), .IMG_H(2), .K(1), .STRIDE(1), .IMG_AW(6), .KER_AW(4)) u_c (
    .clk(clk), .rst(rst), .start(start && cfg == 2), .busy(busy_a[2]), .img_addr(img_a[2]),
    .ker_addr(ker_a[2]), .valid(valid_a[2]), .ready(ready), .win_last(wl_a[2]),
    .frame_last(fl_a[2]), .done(done_a[2]), .state(st_a[2]));

  logic [5:0] obs_img;
  logic [3:0] obs_ker;
  logic       obs_valid, obs_busy, obs_done, obs_wl, obs_fl;
  state_t     obs_state;

  always_comb begin
    case (cfg)
      1: begin
        obs_img = img_a[1]; obs_ker = ker_a[1]; obs_valid = valid_a[1]; obs_busy = busy_a[1];
        obs_done = done_a[1]; obs_wl = wl_a[1]; obs_fl = fl_a[1]; obs_state = st_a[1];
      end
      2: begin
        obs_img = img_a[2]; obs_ker = ker_a[2]; obs_valid = valid_a[2]; obs_busy = busy_a[2];
        obs_done = done_a[2]; obs_wl = wl_a[2]; obs_fl = fl_a[2]; obs_state = st_a[2];
      end
      default: begin
        obs_img = img_a[0]; obs_ker = ker_a[0]; obs_valid = valid_a[0]; obs_busy = busy_a[0];
        obs_done = done_a[0]; obs_wl = wl_a[0]; obs_fl = fl_a[0]; obs_state = st_a[0];
      end
    endcase
  end

  // Scoreboard: {frame_last, win_last, ker_addr, img_addr} per expected beat
  logic [11:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: enumerate output positions and taps straight from the geometry.
  task automatic build_exp(input int w, input int h, input int k, input int s);
    int ow, oh;
    logic [5:0] ia;
    logic [3:0] ka;
    logic wl, fl;
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    exp_q.delete();
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            ia = 6'((r * s + kr) * w + c * s + kc);
            ka = 4'(kr * k + kc);
            wl = (kr == k - 1) && (kc == k - 1);
            fl = wl && (r == oh - 1) && (c == ow - 1);
            exp_q.push_back({fl, wl, ka, ia});
          end
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random. rst_beat < 0 disables reset.
  task automatic run_frame(input int c, input int rmode, input bit pokes,
                           input int rst_beat, input int total);
    logic [11:0] got, snap, e;
    int acc, cyc;
    bit stalled, hit_done;
    logic [3:0] pat;
    acc = 0; cyc = 0; stalled = 0; hit_done = 0; snap = '0; pat = 4'b1001;
    cfg = c;
    build_exp(cw[c], ch[c], ck[c], cs[c]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 32'(obs_busy), 32'd1);
    check("valid_latency", 32'(obs_valid), 32'd1);
    check("first_img", 32'(obs_img), 32'd0);
    check("first_ker", 32'(obs_ker), 32'd0);
    while (cyc < 4000) begin
      if (obs_done) begin
        hit_done = 1'b1;
        break;
      end
      if (rst_beat >= 0 && acc == rst_beat) begin
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_busy", 32'(obs_busy), 32'd0);
        check("rst_img", 32'(obs_img), 32'd0);
        check("rst_ker", 32'(obs_ker), 32'd0);
        check("rst_done", 32'(obs_done), 32'd0);
        @(negedge clk); rst = 1'b0; ready = 1'b0;
        @(negedge clk);
        check("rst_no_done", 32'(obs_done), 32'd0);
        check("rst_idle", 32'(obs_state), 32'(ST_IDLE));
        return;
      end
      got = {obs_fl, obs_wl, obs_ker, obs_img};
      check("valid_run", 32'(obs_valid), 32'd1);
      if (!obs_valid) break;
      if (stalled) check("stall_hold", 32'(got), 32'(snap));
      case (rmode)
        0: ready = 1'b1;
        1: ready = pat[cyc % 4];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(acc), 32'(total - 1));
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(got), 32'(e));
        end
        acc++;
      end
      stalled = !ready;
      snap = got;
      start = pokes && (acc == 3 || acc == 20);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(hit_done), 32'd1);
    check("beat_count", 32'(acc), 32'(total));
    check("busy_with_done", 32'(obs_busy), 32'd0);
    check("valid_with_done", 32'(obs_valid), 32'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; ready = 1'b0;
    check("done_one_cycle", 32'(obs_done), 32'd0);
    check("start_on_done_ignored", 32'(obs_valid), 32'd0);
    check("back_to_idle", 32'(obs_state), 32'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; cfg = 0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      cfg = c;
      #1;
      check("reset_valid", 32'(obs_valid), 32'd0);
      check("reset_busy", 32'(obs_busy), 32'd0);
      check("reset_done", 32'(obs_done), 32'd0);
      check("reset_flags", 32'({obs_wl, obs_fl}), 32'd0);
      check("reset_addr", 32'({obs_img, obs_ker}), 32'd0);
      check("reset_state", 32'(obs_state), 32'(ST_IDLE));
    end
    @(negedge clk); rst = 1'b0;

    run_frame(0, 0, 1'b0, -1, 36);
    run_frame(0, 1, 1'b0, -1, 36);
    run_frame(1, 0, 1'b0, -1, 36);
    run_frame(0, 0, 1'b1, -1, 36);
    run_frame(0, 0, 1'b0, 10, 36);
    run_frame(0, 0, 1'b0, -1, 36);
    run_frame(2, 0, 1'b0, -1, 4);
    run_frame(0, 2, 1'b1, -1, 36);
    run_frame(1, 2, 1'b0, -1, 36);
    run_frame(2, 2, 1'b0, -1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_addr_gen.md
# conv_window_addr_gen

Address generator that sits directly upstream of the convolution MAC/accumulator stage. After a `start` pulse it walks every output position of a valid-mode 2-D convolution. For each position it emits the K×K image-buffer and kernel-buffer read addresses in raster order, flagging the last beat of each window and of the whole frame. Addresses are handed downstream under a valid/ready handshake, so the MAC can stall the walk.

## Interface
Parameters:
- `IMG_W`, default 8: image width in pixels, ≥ K.
- `IMG_H`, default 8: image height in pixels, ≥ K.
- `K`, default 3: kernel side length, ≥ 1.
- `STRIDE`, default 1: window step in both axes, ≥ 1.
- `IMG_AW`, default 6: image address width; must hold IMG_W·IMG_H−1.
- `KER_AW`, default 4: kernel address width; must hold K·K−1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a frame; honoured only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `img_addr` out IMG_AW: image-buffer read address.
- `ker_addr` out KER_AW: kernel-buffer read address.
- `valid` out 1: `img_addr`, `ker_addr`, `win_last` and `frame_last` are meaningful.
- `ready` in 1: downstream accepts the beat when `valid && ready`.
- `win_last` out 1: the current beat is the final (kr=K−1, kc=K−1) tap of its window.
- `frame_last` out 1: the current beat is the final beat of the frame.
- `done` out 1: one-cycle pulse after the `frame_last` beat is accepted.

## Operation
- Derived constants:
  - OW = (IMG_W−K)/STRIDE + 1 and OH = (IMG_H−K)/STRIDE + 1, using integer floor; leftover columns/rows are skipped.
  - Total beats per frame = OH·OW·K·K.
- Four nested modulo counters, innermost first: kc (mod K), kr (mod K), oc (mod OW), or (mod OH). Each inner counter's terminal count enables the next outer counter.
- Address arithmetic:
  - `img_addr` = (or·STRIDE + kr)·IMG_W + oc·STRIDE + kc.
  - `ker_addr` = kr·K + kc.
  - Both are computed at full precision, then truncated to their port widths. Truncation never occurs when the width parameters are legal.
- FSM:
  - IDLE: counters at 0, `valid`=0. `start`=1 → RUN.
  - RUN: `valid`=1. On `valid && ready` the counters advance. On `valid && ready && frame_last` → DONE.
  - DONE: `valid`=0, `done`=1 for exactly one cycle → IDLE.
- Outputs are registered. Address, flag and `valid` outputs are driven from counter/state registers, never from `ready` combinationally.
- Stall: while `valid && !ready`, every output holds its value.
- `start` during RUN or DONE is ignored and is not queued.
- `start` asserted in the same cycle as the `done` pulse is ignored.

## Timing
- Reset values: state IDLE, all counters 0, `valid`=0, `busy`=0, `done`=0, `win_last`=0, `frame_last`=0, `img_addr`=0, `ker_addr`=0.
- Reset is honoured mid-frame: outputs return to their reset values immediately, with no `done` pulse.
- Latency: `start` sampled at edge t → `valid`=1 with `img_addr`=0 and `ker_addr`=0 from t+1.
- With `ready` held high, one beat is accepted per cycle, giving OH·OW·K·K consecutive valid cycles.
- `done` is high in the cycle after the final accepted beat; `busy` falls in the same cycle as that `done` pulse.
- The earliest next `start` is honoured in the cycle after `done`.
- For K=1, every beat has `win_last`=1.
- For OH=OW=1, `frame_last` coincides with the first `win_last`.

## Structure
- Shared package `cnn_pkg`: FSM state typedef (IDLE/RUN/DONE) and a `clog2`-based width helper function.
- The OW/OH localparams are derived inside the block.
- Sub-module `mod_counter` (parameter MOD; ports clk, rst, en, count, tc), instantiated four times in a cascade.
- Address multiply-adds are plain combinational logic feeding the output registers.

## Test plan
- IMG=4×4, K=3, STRIDE=1, `ready`=1, `start` pulse:
  - First window `img_addr` = 0,1,2,4,5,6,8,9,10, with `win_last` on the 9th beat.
  - Window 2 starts at 1 and window 3 starts at 4.
  - Final beat `img_addr`=15 with `frame_last`=1.
  - Exactly 36 valid beats; `done` pulses once, one cycle later.
- Same configuration with `ready` toggling 1,0,0,1,…: outputs are frozen during every `ready`=0 cycle, and the accepted address sequence is identical to the previous test.
- IMG=5×5, K=3, STRIDE=2:
  - OW=OH=2, so window starts are 0, 2, 10, 12.
  - `ker_addr` repeats 0..8 per window.
  - 36 beats in total.
- `start` reasserted at beats 3 and 20 of a frame: no effect on the sequence; only one `done` pulse.
- `rst` asserted at beat 10: `valid`, `busy` and the addresses drop to 0 immediately, with no `done`. A new `start` then restarts the frame from `img_addr`=0.
- K=1, IMG=2×2, STRIDE=1: 4 beats with `img_addr` 0,1,2,3, `ker_addr`=0 throughout, and `win_last`=1 on every beat.
